hdmi_frame_reader: RTL and testbench

HDMI_FRAME_READER -- requirements
Module: hdmi_frame_reader

---
 rtl/hdmi_frame_reader.sv | 163 ++++++++++++++++
 tb/tb_hdmi_frame_reader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_frame_reader.sv
// Frame-buffer read-command generator: on each vsync, walks one frame of the selected
// buffer and issues burst read commands while the downstream data FIFO has room.
module hdmi_frame_reader #(
    parameter int          FRAME_WORDS = 307200,
    parameter int          BURST       = 64,
    parameter int          FIFO_DEPTH  = 512,
    parameter logic [31:0] BASE_A      = 32'h0000_0000,
    parameter logic [31:0] BASE_B      = 32'h0200_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        frame_select,
    input  logic        vsync,
    output logic [39:0] rd_ctrl_in,
    output logic        rd_ctrl_we,
    input  logic        rd_ctrl_full,
    input  logic        pix_pop,
    output logic        frame_done,
    output logic        busy,
    output logic        underflow,
    output logic        overrun
);

    localparam int WLW = $clog2(FRAME_WORDS + 1);
    localparam int LVW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS,
        LATCH,
        ISSUE,
        DONE
    } state_t;

    state_t          r_state;
    logic [31:0]     r_addr;
    logic [WLW-1:0]  r_words_left;
    logic [LVW-1:0]  r_level;
    logic [39:0]     r_rd_ctrl_in;
    logic            r_rd_ctrl_we;
    logic            r_frame_done;
    logic            r_busy;
    logic            r_underflow;
    logic            r_overrun;

    logic [7:0]      w_len;
    logic            w_credit_ok;
    logic            w_last;
    logic            w_issue;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        w_len = 8'(BURST);
        if (32'(r_words_left) < 32'(BURST)) begin
            w_len = 8'(r_words_left);
        end
    end

    // Level already includes everything requested, so this bounds FIFO occupancy.
    assign w_credit_ok = (32'(r_level) + 32'(w_len)) <= 32'(FIFO_DEPTH);
    assign w_last      = 32'(r_words_left) == 32'(w_len);
    assign w_issue     = enable && (r_state == ISSUE) && !rd_ctrl_full && w_credit_ok;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_words_left <= '0;
            r_rd_ctrl_in <= '0;
            r_rd_ctrl_we <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_rd_ctrl_we <= 1'b0;
            r_frame_done <= 1'b0;
            if (r_state == IDLE) begin
                r_overrun <= 1'b0;
            end
            if (!enable) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= WAIT_VS;
                    end
                    WAIT_VS: begin
                        if (vsync) begin
                            r_state <= LATCH;
                            r_busy  <= 1'b1;
                        end
                    end
                    LATCH: begin
                        r_addr       <= frame_select ? BASE_B : BASE_A;
                        r_words_left <= WLW'(FRAME_WORDS);
                        r_state      <= ISSUE;
                        if (vsync) begin
                            r_overrun <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        if (vsync) begin
                            r_overrun <= 1'b1;
                        end
                        if (w_issue) begin
                            r_rd_ctrl_in <= {w_len, r_addr};
                            r_rd_ctrl_we <= 1'b1;
                            r_addr       <= r_addr + 32'({w_len, 2'b00});
                            r_words_left <= r_words_left - WLW'(w_len);
                            if (w_last) begin
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    DONE: begin
                        r_frame_done <= 1'b1;
                        r_state      <= WAIT_VS;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Outstanding words: requested by commands but not yet consumed by the display.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level     <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_issue && pix_pop) begin
                r_level <= r_level + LVW'(w_len) - LVW'(1);
            end else if (w_issue) begin
                r_level <= r_level + LVW'(w_len);
            end else if (pix_pop) begin
                if (r_level != '0) begin
                    r_level <= r_level - LVW'(1);
                end
            end

            if (r_state == IDLE) begin
                r_underflow <= 1'b0;
            end else if (pix_pop && !w_issue && (r_level == '0)) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign rd_ctrl_in = r_rd_ctrl_in;
    assign rd_ctrl_we = r_rd_ctrl_we;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;
    assign underflow  = r_underflow;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_hdmi_frame_reader.sv
// Bench for hdmi_frame_reader: a 130-word instance with a deep FIFO checked by a command
// scoreboard, plus a 256-word instance with a 128-word FIFO for the credit-stall case.
module tb_hdmi_frame_reader;

    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam logic [31:0] BASE_B = 32'h0200_0000;

    typedef struct {
        logic        fsel;
        logic        toggle;
        logic [31:0] base;
    } frame_vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        en_b = 1'b0;
    logic        frame_select = 1'b0;
    logic        vsync = 1'b0;
    logic        rd_ctrl_full = 1'b0;
    logic        pix_pop = 1'b0;
    logic        pop_b = 1'b0;

    logic [39:0] a_cmd, b_cmd;
    logic        a_we, a_done, a_busy, a_under, a_over;
    logic        b_we, b_done, b_busy, b_under, b_over;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          a_cnt = 0;
    int          b_cnt = 0;
    int          lvl = 0;
    int          start;
    int          cnt0;
    logic        auto_pop = 1'b0;
    logic        a_we_seen = 1'b0;
    logic [39:0] b_last = '0;
    logic [39:0] exp_q[$];
    frame_vec_t  vecs[4];

    always #5 clk = ~clk;

    hdmi_frame_reader #(
        .FRAME_WORDS(130), .BURST(64), .FIFO_DEPTH(512), .BASE_A(BASE_A), .BASE_B(BASE_B)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .frame_select(frame_select), .vsync(vsync),
        .rd_ctrl_in(a_cmd), .rd_ctrl_we(a_we), .rd_ctrl_full(rd_ctrl_full), .pix_pop(pix_pop),
        .frame_done(a_done), .busy(a_busy), .underflow(a_under), .overrun(a_over)
    );

    hdmi_frame_reader #(
        .FRAME_WORDS(256), .BURST(64), .FIFO_DEPTH(128), .BASE_A(BASE_A), .BASE_B(BASE_B)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .frame_select(frame_select), .vsync(vsync),
        .rd_ctrl_in(b_cmd), .rd_ctrl_we(b_we), .rd_ctrl_full(rd_ctrl_full), .pix_pop(pop_b),
        .frame_done(b_done), .busy(b_busy), .underflow(b_under), .overrun(b_over)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected command list for one 130-word frame starting at base.
    task automatic push_frame(input logic [31:0] base);
        int          left;
        int          len;
        logic [31:0] addr;
        left = 130;
        addr = base;
        while (left > 0) begin
            len = (left > 64) ? 64 : left;
            exp_q.push_back({8'(len), addr});
            addr = addr + 32'(4 * len);
            left = left - len;
        end
    endtask

    // One clock: sample outputs at the falling edge, score commands, then update pop stimulus.
    task automatic tick();
        logic p;
        logic [39:0] e;
        p = pix_pop;
        @(negedge clk);
        vsync = 1'b0;
        a_we_seen = a_we;
        if (a_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cmd_unexpected: got %0h expected no command", a_cmd);
            end else begin
                e = exp_q.pop_front();
                check("cmd", a_cmd, e);
            end
            a_cnt++;
            lvl = lvl + int'(a_cmd[39:32]);
        end
        if (p) lvl = (lvl > 0) ? lvl - 1 : 0;
        if (!rst) lvl = 0;
        if (a_done) done_cnt++;
        if (b_we) begin
            b_cnt++;
            b_last = b_cmd;
        end
        if (auto_pop) pix_pop = (lvl > 0);
    endtask

    task automatic wait_done(input int bound, input logic toggle);
        for (int c = 0; c < bound; c++) begin
            if (done_cnt != start) break;
            if (toggle) frame_select = ~frame_select;
            tick();
        end
        check("frame_done_seen", 64'(done_cnt - start), 1);
        check("all_cmds_seen", 64'(exp_q.size()), 0);
    endtask

    task automatic drain();
        for (int c = 0; c < 400; c++) begin
            if (lvl == 0) break;
            tick();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd"}, a_cmd, 0);
        check({tag, "_we"}, a_we, 0);
        check({tag, "_done"}, a_done, 0);
        check({tag, "_busy"}, a_busy, 0);
        check({tag, "_under"}, a_under, 0);
        check({tag, "_over"}, a_over, 0);
    endtask

    initial begin
        vecs[0] = '{fsel: 1'b0, toggle: 1'b0, base: BASE_A};
        vecs[1] = '{fsel: 1'b1, toggle: 1'b1, base: BASE_B};
        vecs[2] = '{fsel: 1'b0, toggle: 1'b1, base: BASE_A};
        vecs[3] = '{fsel: 1'b1, toggle: 1'b0, base: BASE_B};

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        enable = 1'b1;
        auto_pop = 1'b1;
        repeat (3) tick();
        check("idle_busy", a_busy, 0);

        // Frames from the table: select latched once, toggling during ISSUE has no effect.
        for (int i = 0; i < 4; i++) begin
            frame_select = vecs[i].fsel;
            push_frame(vecs[i].base);
            start = done_cnt;
            vsync = 1'b1;
            tick();
            tick();
            check("busy_in_issue", a_busy, 1);
            wait_done(100, vecs[i].toggle);
            repeat (3) tick();
            check("frame_done_once", 64'(done_cnt - start), 1);
            check("busy_after_done", a_busy, 0);
            drain();
            frame_select = 1'b0;
        end

        // Credit stall on the shallow-FIFO instance.
        enable = 1'b0;
        auto_pop = 1'b0;
        pix_pop = 1'b0;
        tick();
        en_b = 1'b1;
        tick();
        vsync = 1'b1;
        tick();
        repeat (20) tick();
        check("credit_two_cmds", 64'(b_cnt), 2);
        check("credit_second_cmd", b_last, {8'd64, 32'h0000_0100});
        pop_b = 1'b1;
        repeat (63) tick();
        pop_b = 1'b0;
        repeat (5) tick();
        check("credit_63_pops_stalled", 64'(b_cnt), 2);
        pop_b = 1'b1;
        tick();
        pop_b = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (b_cnt == 3) break;
            tick();
        end
        check("credit_64th_pop_issues", 64'(b_cnt), 3);
        check("credit_third_cmd", b_last, {8'd64, 32'h0000_0200});
        en_b = 1'b0;
        tick();

        // Command FIFO full for 10 cycles in ISSUE.
        enable = 1'b1;
        auto_pop = 1'b1;
        repeat (2) tick();
        rd_ctrl_full = 1'b1;
        push_frame(BASE_A);
        start = done_cnt;
        vsync = 1'b1;
        tick();
        tick();
        cnt0 = a_cnt;
        repeat (10) tick();
        check("full_no_we", 64'(a_cnt - cnt0), 0);
        rd_ctrl_full = 1'b0;
        tick();
        check("full_release_we", a_we_seen, 1);
        wait_done(100, 1'b0);
        drain();

        // vsync during ISSUE, then underflow, then flags cleared by disable.
        push_frame(BASE_A);
        start = done_cnt;
        vsync = 1'b1;
        tick();
        tick();
        vsync = 1'b1;
        tick();
        wait_done(100, 1'b0);
        check("overrun_set", a_over, 1);
        repeat (5) tick();
        check("overrun_no_restart", 64'(done_cnt - start), 1);
        drain();
        auto_pop = 1'b0;
        pix_pop = 1'b0;
        tick();
        check("underflow_clear_before", a_under, 0);
        pix_pop = 1'b1;
        tick();
        pix_pop = 1'b0;
        tick();
        check("underflow_set", a_under, 1);
        check("overrun_sticky", a_over, 1);
        enable = 1'b0;
        repeat (2) tick();
        check("underflow_cleared", a_under, 0);
        check("overrun_cleared", a_over, 0);

        // Reset between bursts, then a clean restart from the buffer base.
        enable = 1'b1;
        auto_pop = 1'b1;
        repeat (2) tick();
        frame_select = 1'b1;
        exp_q.push_back({8'd64, BASE_B});
        vsync = 1'b1;
        tick();
        tick();
        tick();
        check("pre_reset_first_cmd", a_we_seen, 1);
        rd_ctrl_full = 1'b1;
        repeat (3) tick();
        check("pre_reset_busy", a_busy, 1);
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) tick();
        rst = 1'b1;
        rd_ctrl_full = 1'b0;
        repeat (4) tick();
        check("no_partial_after_reset", 64'(exp_q.size()), 0);
        push_frame(BASE_B);
        start = done_cnt;
        vsync = 1'b1;
        tick();
        wait_done(100, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
